// File: rtl/lc3_pkg.sv
// Shared LC3-2 definitions for the data-memory access stage: opcodes and FSM states.
package lc3_pkg;

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [2:0] {
        IDLE,
        IND,
        RD,
        WR,
        DONE
    } mem_state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return op inside {OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI};
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Per-access wait counter: clears on entry to an access, expires after TIMEOUT wait cycles.
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic cnt_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (cnt_i) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expires on the wait cycle that would bring the count up to the limit.
    assign expire_o = cnt_i && ((count_q + CntW'(1)) == Limit);

endmodule

// File: rtl/mem_access.sv
// LC3-2 data-memory access stage (LD/LDR/LDI/ST/STR/STI over a ready handshake).
// Optional per-access watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access
    import lc3_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Mem_Control_in,
    input  logic [15:0] IR_Exec,
    input  logic [15:0] pcout,
    input  logic [15:0] M_Data,
    output logic        dmem_en,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_din,
    input  logic [15:0] dmem_dout,
    input  logic        dmem_rdy,
    output logic [15:0] memout,
    output logic        mem_done,
    output logic        stall_mem,
    output logic        mem_err
);

    mem_state_t  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] memout_q, memout_d;
    logic [3:0]  op_q, op_d;
    logic        err_q, err_d;

    logic [3:0] opcode;
    logic       accept;
    logic       wd_clr, wd_cnt, wd_expire;
    logic       unused_ir;

    assign opcode    = IR_Exec[15:12];
    assign unused_ir = ^IR_Exec[11:0];
    assign accept    = (state_q == IDLE) && Mem_Control_in && is_mem_op(opcode);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        op_d      = op_q;
        memout_d  = memout_q;
        err_d     = 1'b0;
        dmem_en   = 1'b0;
        dmem_we   = 1'b0;
        dmem_addr = '0;
        dmem_din  = '0;
        mem_done  = 1'b0;
        stall_mem = 1'b0;
        wd_clr    = 1'b0;
        wd_cnt    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    stall_mem = 1'b1;
                    wd_clr    = 1'b1;
                    addr_d    = pcout;
                    data_d    = M_Data;
                    op_d      = opcode;
                    if (opcode == OP_LDI || opcode == OP_STI) begin
                        state_d = IND;
                    end else if (opcode == OP_LD || opcode == OP_LDR) begin
                        state_d = RD;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            IND, RD, WR: begin
                stall_mem = 1'b1;
                dmem_en   = 1'b1;
                dmem_addr = addr_q;
                wd_cnt    = !dmem_rdy;
                if (state_q == WR) begin
                    dmem_we  = 1'b1;
                    dmem_din = data_q;
                end
                if (dmem_rdy) begin
                    if (state_q == IND) begin
                        // Pointer fetched; second access goes to the pointed-to address.
                        addr_d  = dmem_dout;
                        wd_clr  = 1'b1;
                        state_d = (op_q == OP_LDI) ? RD : WR;
                    end else begin
                        if (state_q == RD) begin
                            memout_d = dmem_dout;
                        end
                        state_d = DONE;
                    end
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                mem_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            memout_q <= '0;
            op_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            memout_q <= memout_d;
            op_q     <= op_d;
            err_q    <= err_d;
        end
    end

    assign memout = memout_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    mem_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (wd_clr),
        .cnt_i   (wd_cnt),
        .expire_o(wd_expire)
    );

    assign mem_err = err_q;
`else
    logic unused_wd;
    assign unused_wd = ^{wd_clr, wd_cnt, err_q, TIMEOUT};
    assign wd_expire = 1'b0;
    assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a transaction-level memory/load model.
module tb_mem_access;
    import lc3_pkg::*;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        Mem_Control_in;
    logic [15:0] IR_Exec, pcout, M_Data;
    logic        dmem_en, dmem_we;
    logic [15:0] dmem_addr, dmem_din, dmem_dout;
    logic        dmem_rdy;
    logic [15:0] memout;
    logic        mem_done, stall_mem, mem_err;

    logic [15:0] mem     [65536];
    logic [15:0] ref_mem [65536];
    logic [15:0] ref_memout;
    logic [15:0] junk;
    int          n_vec = 0;
    int          n_err = 0;

    logic [3:0] ops [6];

    always #5 clk = ~clk;

    mem_access #(
        .TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Mem_Control_in(Mem_Control_in),
        .IR_Exec       (IR_Exec),
        .pcout         (pcout),
        .M_Data        (M_Data),
        .dmem_en       (dmem_en),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_din      (dmem_din),
        .dmem_dout     (dmem_dout),
        .dmem_rdy      (dmem_rdy),
        .memout        (memout),
        .mem_done      (mem_done),
        .stall_mem     (stall_mem),
        .mem_err       (mem_err)
    );

    // Slave memory: read data only meaningful when ready.
    assign dmem_dout = dmem_rdy ? mem[dmem_addr] : junk;

    always @(posedge clk) begin
        if (dmem_en && dmem_we && dmem_rdy) mem[dmem_addr] <= dmem_din;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        Mem_Control_in = 1'($urandom);
        IR_Exec        = 16'($urandom);
        pcout          = 16'($urandom);
        M_Data         = 16'($urandom);
        junk           = 16'($urandom);
    endtask

    task automatic run_access(input string tag, input logic [15:0] exp_addr, input logic exp_we,
                              input logic [15:0] exp_din, input int waits);
        for (int w = 0; w <= waits; w++) begin
            scramble_inputs();
            dmem_rdy = (w == waits);
            #1;
            check_eq({tag, "_en"}, 16'(dmem_en), 16'd1);
            check_eq({tag, "_we"}, 16'(dmem_we), 16'(exp_we));
            check_eq({tag, "_addr"}, dmem_addr, exp_addr);
            if (exp_we) check_eq({tag, "_din"}, dmem_din, exp_din);
            check_eq({tag, "_stall"}, 16'(stall_mem), 16'd1);
            check_eq({tag, "_nodone"}, 16'(mem_done), 16'd0);
            check_eq({tag, "_memhold"}, memout, ref_memout);
            next_cycle();
        end
    endtask

    task automatic do_txn(input logic [3:0] op, input logic [15:0] pc, input logic [15:0] d,
                          input int w1, input int w2);
        logic        ind, wr;
        logic [15:0] a;
        ind = (op == OP_LDI) || (op == OP_STI);
        wr  = (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
        Mem_Control_in = 1'b1;
        IR_Exec        = {op, 12'($urandom)};
        pcout          = pc;
        M_Data         = d;
        dmem_rdy       = 1'($urandom);
        #1;
        check_eq("accept_stall", 16'(stall_mem), 16'd1);
        check_eq("accept_noen", 16'(dmem_en), 16'd0);
        next_cycle();
        a = pc;
        if (ind) begin
            run_access("ind", pc, 1'b0, 16'h0, w1);
            a = ref_mem[pc];
        end
        if (wr) begin
            run_access("wr", a, 1'b1, d, w2);
            ref_mem[a] = d;
        end else begin
            run_access("rd", a, 1'b0, 16'h0, w2);
            ref_memout = ref_mem[a];
        end
        // DONE cycle: a legal request here must be ignored.
        Mem_Control_in = 1'b1;
        IR_Exec        = {ops[$urandom_range(0, 5)], 12'($urandom)};
        dmem_rdy       = 1'($urandom);
        #1;
        check_eq("done_pulse", 16'(mem_done), 16'd1);
        check_eq("done_memout", memout, ref_memout);
        check_eq("done_nostall", 16'(stall_mem), 16'd0);
        check_eq("done_noen", 16'(dmem_en), 16'd0);
        check_eq("done_noerr", 16'(mem_err), 16'd0);
        next_cycle();
        Mem_Control_in = 1'b0;
        #1;
        check_eq("idle_nodone", 16'(mem_done), 16'd0);
    endtask

    initial begin
        logic [3:0] bad_op;
        ops[0] = OP_LD;  ops[1] = OP_LDR; ops[2] = OP_LDI;
        ops[3] = OP_ST;  ops[4] = OP_STR; ops[5] = OP_STI;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        ref_memout     = 16'h0;
        rst            = 1'b0;
        Mem_Control_in = 1'b0;
        IR_Exec        = 16'h0;
        pcout          = 16'h0;
        M_Data         = 16'h0;
        dmem_rdy       = 1'b0;
        junk           = 16'h0;
        next_cycle();
        next_cycle();
        check_eq("rst_en", 16'(dmem_en), 16'd0);
        check_eq("rst_we", 16'(dmem_we), 16'd0);
        check_eq("rst_addr", dmem_addr, 16'h0);
        check_eq("rst_din", dmem_din, 16'h0);
        check_eq("rst_memout", memout, 16'h0);
        check_eq("rst_done", 16'(mem_done), 16'd0);
        check_eq("rst_err", 16'(mem_err), 16'd0);
        check_eq("rst_stall", 16'(stall_mem), 16'd0);
        rst = 1'b1;
        next_cycle();

        mem[16'h3010] = 16'hBEEF; ref_mem[16'h3010] = 16'hBEEF;
        do_txn(OP_LD, 16'h3010, 16'h0, 0, 0);
        mem[16'h3000] = 16'h4000; ref_mem[16'h3000] = 16'h4000;
        do_txn(OP_STI, 16'h3000, 16'h1234, 0, 0);
        do_txn(OP_LDI, 16'h3000, 16'h0, 0, 0);
        check_eq("sti_then_ldi", memout, 16'h1234);
        do_txn(OP_LDR, 16'h5555, 16'h0, 0, 3);

        for (int n = 0; n < 40; n++) begin
            do_txn(ops[$urandom_range(0, 5)], 16'($urandom), 16'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Non-memory opcodes with a valid request are ignored.
        for (int n = 0; n < 6; n++) begin
            do bad_op = 4'($urandom); while (is_mem_op(bad_op));
            Mem_Control_in = 1'b1;
            IR_Exec        = {bad_op, 12'($urandom)};
            dmem_rdy       = 1'($urandom);
            #1;
            check_eq("bad_noen", 16'(dmem_en), 16'd0);
            check_eq("bad_nostall", 16'(stall_mem), 16'd0);
            next_cycle();
            check_eq("bad_nodone", 16'(mem_done), 16'd0);
        end
        Mem_Control_in = 1'b0;

        // Reset in the middle of the read phase of an LDI.
        Mem_Control_in = 1'b1;
        IR_Exec        = {OP_LDI, 12'h0};
        pcout          = 16'h0100;
        dmem_rdy       = 1'b1;
        next_cycle();
        Mem_Control_in = 1'b0;
        dmem_rdy       = 1'b1;
        next_cycle();
        dmem_rdy = 1'b0;
        rst      = 1'b0;
        #1;
        check_eq("rstmid_rd_en", 16'(dmem_en), 16'd1);
        next_cycle();
        rst = 1'b1;
        ref_memout = 16'h0;
        #1;
        check_eq("rstmid_noen", 16'(dmem_en), 16'd0);
        check_eq("rstmid_memout", memout, ref_memout);
        check_eq("rstmid_nodone", 16'(mem_done), 16'd0);
        check_eq("rstmid_nostall", 16'(stall_mem), 16'd0);
        next_cycle();
        check_eq("rstmid_nodone2", 16'(mem_done), 16'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        do_txn(OP_LD, 16'h0200, 16'h0, 0, 0);
        Mem_Control_in = 1'b1;
        IR_Exec        = {OP_LD, 12'h0};
        pcout          = 16'h0300;
        dmem_rdy       = 1'b0;
        next_cycle();
        Mem_Control_in = 1'b0;
        for (int w = 0; w < int'(TO); w++) begin
            check_eq("to_wait_en", 16'(dmem_en), 16'd1);
            next_cycle();
        end
        check_eq("to_done", 16'(mem_done), 16'd1);
        check_eq("to_err", 16'(mem_err), 16'd1);
        check_eq("to_memout", memout, ref_memout);
        check_eq("to_noen", 16'(dmem_en), 16'd0);
        next_cycle();
        check_eq("to_err_clear", 16'(mem_err), 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
